// File: rtl/reset_sequencer_if.sv
// Bundle between the reset sequencer and the domains it controls, plus debug
// visibility of the sequencer FSM.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);

  // Handshake: reset_out[k] falling is the release request for domain k; the
  // domain answers by holding domain_ack[k] high once its synchronized reset
  // has deasserted, and the sequencer advances only on that level. sw_req is
  // a single-cycle pulse, sampled only while the sequencer is in RUN or FAULT.
  logic [NUM_DOMAINS-1:0] sw_req;
  logic [NUM_DOMAINS-1:0] domain_ack;
  logic [NUM_DOMAINS-1:0] reset_out;
  logic                   busy;
  logic                   fault;
  logic [2:0]             fault_domain;
  logic [2:0]             state;
  logic [2:0]             idx;

  modport master (
    input  sw_req, domain_ack,
    output reset_out, busy, fault, fault_domain, state, idx
  );

  modport slave (
    output sw_req, domain_ack,
    input  reset_out, busy, fault, fault_domain, state, idx
  );

endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: keeps all domains in reset until the PLL is stably locked,
// then releases them one by one in index order, waiting for each acknowledge.
module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 256,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              areset,
  input  logic              pll_locked,
  reset_sequencer_if.master bus
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] HOLD_TARGET = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] ACK_TARGET  = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [2:0]       LAST_IDX    = 3'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    RELEASE  = 3'd1,
    WAIT_ACK = 3'd2,
    RUN      = 3'd3,
    FAULT    = 3'd4
  } state_t;

  logic                   lock_meta;
  logic                   lock_sync;
  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic [2:0]             fdom_q, fdom_d;

  logic [CNT_W-1:0]       cnt_inc;
  logic                   sw_hit;
  logic [2:0]             sw_idx;
  logic [NUM_DOMAINS-1:0] idx_onehot;
  logic [NUM_DOMAINS-1:0] idx_upper;
  logic [NUM_DOMAINS-1:0] sw_upper;
  logic                   ack_sel;

  // Shared helpers: saturating count, lowest requested domain, index masks.
  always_comb begin
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    sw_hit  = 1'b0;
    sw_idx  = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (bus.sw_req[i]) begin
        sw_hit = 1'b1;
        sw_idx = 3'(i);
      end
    end
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      idx_onehot[i] = (3'(i) == idx_q);
      idx_upper[i]  = (3'(i) >= idx_q);
      sw_upper[i]   = (3'(i) >= sw_idx);
    end
    ack_sel = |(bus.domain_ack & idx_onehot);
  end

  // State register; the lock synchronizer shares the same asynchronous reset.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      state_q   <= HOLD;
      idx_q     <= '0;
      cnt_q     <= '0;
      rst_q     <= '1;
      fdom_q    <= '0;
    end else begin
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rst_q     <= rst_d;
      fdom_q    <= fdom_d;
    end
  end

  // Next-state logic. Lock loss overrides everything else, including sw_req.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    fdom_d  = fdom_q;
    if (!lock_sync) begin
      state_d = HOLD;
      idx_d   = '0;
      cnt_d   = '0;
      rst_d   = '1;
    end else begin
      unique case (state_q)
        HOLD: begin
          cnt_d = cnt_inc;
          if (cnt_inc >= HOLD_TARGET) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        end
        RELEASE: begin
          rst_d   = rst_q & ~idx_onehot;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_sel) begin
            cnt_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = RUN;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= ACK_TARGET) begin
              // Re-assert the silent domain and everything above it.
              state_d = FAULT;
              fdom_d  = idx_q;
              rst_d   = rst_q | idx_upper;
              cnt_d   = '0;
            end
          end
        end
        RUN: begin
          rst_d = '0;
          if (sw_hit) begin
            rst_d   = rst_q | sw_upper;
            idx_d   = sw_idx;
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
        FAULT: begin
          if (sw_hit) begin
            rst_d   = rst_q | sw_upper;
            idx_d   = sw_idx;
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
        default: begin
          state_d = HOLD;
          idx_d   = '0;
          cnt_d   = '0;
          rst_d   = '1;
        end
      endcase
    end
  end

  // Output logic: reset_out comes straight from its register, never from logic.
  assign bus.reset_out    = rst_q;
  assign bus.busy         = (state_q != RUN);
  assign bus.fault        = (state_q == FAULT);
  assign bus.fault_domain = fdom_q;
  assign bus.state        = state_q;
  assign bus.idx          = idx_q;

  a_run_released : assert property (@(posedge clock) disable iff (areset)
    (state_q == RUN) |-> (rst_q == '0));

  a_fault_held : assert property (@(posedge clock) disable iff (areset)
    (state_q == FAULT) |-> ((rst_q & idx_upper) == idx_upper));

  a_idx_range : assert property (@(posedge clock) disable iff (areset)
    idx_q <= LAST_IDX);

  a_state_legal : assert property (@(posedge clock) disable iff (areset)
    state_q <= FAULT);

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with N=4, HOLD_CYCLES=16, ACK_TIMEOUT=32;
// timings are counted in falling edges after each stimulus change.
module tb_reset_sequencer;

  localparam int N = 4;
  localparam logic [2:0] ST_HOLD     = 3'd0;
  localparam logic [2:0] ST_RELEASE  = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

  logic         clock = 1'b0;
  logic         areset;
  logic         pll_locked;
  logic [N-1:0] ack_en;
  logic [N-1:0] ack_d1 = '0;

  int n_checks = 0;
  int n_pass   = 0;

  reset_sequencer_if #(.NUM_DOMAINS(N)) bus ();

  reset_sequencer #(
    .NUM_DOMAINS(N),
    .HOLD_CYCLES(16),
    .ACK_TIMEOUT(32)
  ) dut (
    .clock      (clock),
    .areset     (areset),
    .pll_locked (pll_locked),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  // Domain model: each ack follows its released reset two clocks later.
  always @(posedge clock) begin
    ack_d1         <= ~bus.reset_out & ack_en;
    bus.domain_ack <= ack_d1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    areset = 1'b1; pll_locked = 1'b0; bus.sw_req = '0; ack_en = '1;
    tick(1);
    n_checks++; if (bus.reset_out !== 4'b1111) $display("FAIL rst_reset_out: got %b want 1111", bus.reset_out); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", bus.busy); else n_pass++;
    n_checks++; if (bus.fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", bus.fault); else n_pass++;
    n_checks++; if (bus.fault_domain !== 3'd0) $display("FAIL rst_fault_domain: got %0d want 0", bus.fault_domain); else n_pass++;
    n_checks++; if (bus.state !== ST_HOLD || bus.idx !== 3'd0) $display("FAIL rst_state_idx: got %0d/%0d want 0/0", bus.state, bus.idx); else n_pass++;
    tick(1);
    areset = 1'b0;
    tick(1);
    n_checks++; if (bus.reset_out !== 4'b1111) $display("FAIL rst_after_release: got %b want 1111", bus.reset_out); else n_pass++;
  endtask

  task automatic test_power_up();
    logic [N-1:0] exp_r;
    logic         exp_b;
    tick(2);
    pll_locked = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      tick(1);
      exp_r = (i < 19) ? 4'b1111 : (i < 23) ? 4'b1110 : (i < 27) ? 4'b1100 : (i < 31) ? 4'b1000 : 4'b0000;
      exp_b = (i < 34);
      n_checks++; if (bus.reset_out !== exp_r) $display("FAIL pwr_reset_out@%0d: got %b want %b", i, bus.reset_out, exp_r); else n_pass++;
      n_checks++; if (bus.busy !== exp_b) $display("FAIL pwr_busy@%0d: got %b want %b", i, bus.busy, exp_b); else n_pass++;
    end
    n_checks++; if (bus.state !== ST_RUN) $display("FAIL pwr_state: got %0d want %0d", bus.state, ST_RUN); else n_pass++;
  endtask

  task automatic test_sw_reset();
    tick(2);
    bus.sw_req = 4'b0110;
    tick(1);
    bus.sw_req = '0;
    n_checks++; if (bus.reset_out !== 4'b1110) $display("FAIL sw_reset_out: got %b want 1110", bus.reset_out); else n_pass++;
    n_checks++; if (bus.state !== ST_HOLD || bus.idx !== 3'd1) $display("FAIL sw_state_idx: got %0d/%0d want 0/1", bus.state, bus.idx); else n_pass++;
    tick(16);
    n_checks++; if (bus.state !== ST_RELEASE || bus.reset_out !== 4'b1110) $display("FAIL sw_release: got %0d/%b want 1/1110", bus.state, bus.reset_out); else n_pass++;
    tick(1);
    n_checks++; if (bus.reset_out !== 4'b1100) $display("FAIL sw_dom1: got %b want 1100", bus.reset_out); else n_pass++;
    tick(1);
    bus.sw_req = 4'b0001;
    tick(1);
    bus.sw_req = '0;
    n_checks++; if (bus.state !== ST_WAIT_ACK || bus.reset_out !== 4'b1100) $display("FAIL sw_ignored: got %0d/%b want 2/1100", bus.state, bus.reset_out); else n_pass++;
    tick(2);
    n_checks++; if (bus.reset_out !== 4'b1000) $display("FAIL sw_dom2: got %b want 1000", bus.reset_out); else n_pass++;
    tick(4);
    n_checks++; if (bus.reset_out !== 4'b0000 || bus.busy !== 1'b1) $display("FAIL sw_dom3: got %b busy %b want 0000 busy 1", bus.reset_out, bus.busy); else n_pass++;
    tick(3);
    n_checks++; if (bus.busy !== 1'b0 || bus.state !== ST_RUN) $display("FAIL sw_run: got busy %b state %0d want 0/3", bus.busy, bus.state); else n_pass++;
  endtask

  task automatic test_lock_loss_sw();
    tick(1);
    pll_locked = 1'b0;
    tick(2);
    n_checks++; if (bus.state !== ST_RUN || bus.reset_out !== 4'b0000) $display("FAIL loss_pre: got %0d/%b want 3/0000", bus.state, bus.reset_out); else n_pass++;
    bus.sw_req = 4'b1000;
    tick(1);
    bus.sw_req = '0;
    n_checks++; if (bus.reset_out !== 4'b1111) $display("FAIL loss_reset_out: got %b want 1111", bus.reset_out); else n_pass++;
    n_checks++; if (bus.idx !== 3'd0 || bus.state !== ST_HOLD) $display("FAIL loss_idx_state: got %0d/%0d want 0/0", bus.idx, bus.state); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL loss_busy: got %b want 1", bus.busy); else n_pass++;
    tick(3);
    n_checks++; if (bus.reset_out !== 4'b1111 || bus.state !== ST_HOLD) $display("FAIL loss_hold: got %b/%0d want 1111/0", bus.reset_out, bus.state); else n_pass++;
  endtask

  task automatic test_lock_glitch();
    int waited;
    pll_locked = 1'b1;
    tick(12);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    n_checks++; if (bus.state !== ST_HOLD) $display("FAIL glitch_hold13: got %0d want 0", bus.state); else n_pass++;
    tick(6);
    n_checks++; if (bus.reset_out !== 4'b1111 || bus.state !== ST_HOLD) $display("FAIL glitch_no_early: got %b/%0d want 1111/0", bus.reset_out, bus.state); else n_pass++;
    tick(11);
    n_checks++; if (bus.state !== ST_HOLD) $display("FAIL glitch_hold30: got %0d want 0", bus.state); else n_pass++;
    tick(1);
    n_checks++; if (bus.state !== ST_RELEASE || bus.reset_out !== 4'b1111) $display("FAIL glitch_release: got %0d/%b want 1/1111", bus.state, bus.reset_out); else n_pass++;
    tick(1);
    n_checks++; if (bus.reset_out !== 4'b1110) $display("FAIL glitch_dom0: got %b want 1110", bus.reset_out); else n_pass++;
    waited = 0;
    while (bus.busy !== 1'b0 && waited < 40) begin
      tick(1);
      waited++;
    end
    n_checks++; if (bus.busy !== 1'b0 || bus.reset_out !== 4'b0000) $display("FAIL glitch_run: busy %b reset_out %b after %0d cycles, want 0/0000", bus.busy, bus.reset_out, waited); else n_pass++;
  endtask

  task automatic test_timeout();
    int waited;
    ack_en = 4'b1011;
    tick(1);
    bus.sw_req = 4'b0001;
    tick(1);
    bus.sw_req = '0;
    n_checks++; if (bus.reset_out !== 4'b1111 || bus.idx !== 3'd0) $display("FAIL to_restart: got %b idx %0d want 1111 idx 0", bus.reset_out, bus.idx); else n_pass++;
    tick(25);
    n_checks++; if (bus.state !== ST_WAIT_ACK || bus.idx !== 3'd2 || bus.reset_out !== 4'b1000) $display("FAIL to_wait2: got %0d/%0d/%b want 2/2/1000", bus.state, bus.idx, bus.reset_out); else n_pass++;
    tick(31);
    n_checks++; if (bus.state !== ST_WAIT_ACK || bus.fault !== 1'b0) $display("FAIL to_early: got state %0d fault %b want 2/0", bus.state, bus.fault); else n_pass++;
    tick(1);
    n_checks++; if (bus.fault !== 1'b1 || bus.state !== ST_FAULT) $display("FAIL to_fault: got fault %b state %0d want 1/4", bus.fault, bus.state); else n_pass++;
    n_checks++; if (bus.fault_domain !== 3'd2) $display("FAIL to_fault_domain: got %0d want 2", bus.fault_domain); else n_pass++;
    n_checks++; if (bus.reset_out !== 4'b1100 || bus.busy !== 1'b1) $display("FAIL to_reset_out: got %b busy %b want 1100 busy 1", bus.reset_out, bus.busy); else n_pass++;
    tick(10);
    n_checks++; if (bus.fault !== 1'b1 || bus.reset_out !== 4'b1100) $display("FAIL to_stay: got fault %b reset_out %b want 1/1100", bus.fault, bus.reset_out); else n_pass++;
    ack_en = '1;
    bus.sw_req = 4'b0001;
    tick(1);
    bus.sw_req = '0;
    n_checks++; if (bus.reset_out !== 4'b1111 || bus.fault !== 1'b0) $display("FAIL to_recover: got %b fault %b want 1111 fault 0", bus.reset_out, bus.fault); else n_pass++;
    n_checks++; if (bus.state !== ST_HOLD || bus.idx !== 3'd0) $display("FAIL to_recover_state: got %0d/%0d want 0/0", bus.state, bus.idx); else n_pass++;
    waited = 0;
    while (bus.busy !== 1'b0 && waited < 60) begin
      tick(1);
      waited++;
    end
    n_checks++; if (bus.busy !== 1'b0 || bus.reset_out !== 4'b0000) $display("FAIL to_run: busy %b reset_out %b after %0d cycles, want 0/0000", bus.busy, bus.reset_out, waited); else n_pass++;
  endtask

  task automatic test_areset_mid_wait();
    int waited;
    ack_en = 4'b1101;
    tick(1);
    bus.sw_req = 4'b0001;
    tick(1);
    bus.sw_req = '0;
    tick(23);
    n_checks++; if (bus.state !== ST_WAIT_ACK || bus.reset_out !== 4'b1100) $display("FAIL ar_pre: got %0d/%b want 2/1100", bus.state, bus.reset_out); else n_pass++;
    #2 areset = 1'b1;
    #1;
    n_checks++; if (bus.reset_out !== 4'b1111) $display("FAIL ar_async_reset_out: got %b want 1111", bus.reset_out); else n_pass++;
    n_checks++; if (bus.fault !== 1'b0 || bus.busy !== 1'b1) $display("FAIL ar_async_flags: got fault %b busy %b want 0/1", bus.fault, bus.busy); else n_pass++;
    n_checks++; if (bus.state !== ST_HOLD || bus.idx !== 3'd0) $display("FAIL ar_async_state: got %0d/%0d want 0/0", bus.state, bus.idx); else n_pass++;
    tick(1);
    areset = 1'b0;
    ack_en = '1;
    tick(1);
    n_checks++; if (bus.reset_out !== 4'b1111) $display("FAIL ar_post1: got %b want 1111", bus.reset_out); else n_pass++;
    tick(1);
    n_checks++; if (bus.reset_out !== 4'b1111) $display("FAIL ar_post2: got %b want 1111", bus.reset_out); else n_pass++;
    waited = 0;
    while (bus.busy !== 1'b0 && waited < 60) begin
      tick(1);
      waited++;
    end
    n_checks++; if (bus.busy !== 1'b0 || bus.reset_out !== 4'b0000) $display("FAIL ar_run: busy %b reset_out %b after %0d cycles, want 0/0000", bus.busy, bus.reset_out, waited); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_sw_reset();
    test_lock_loss_sw();
    test_lock_glitch();
    test_timeout();
    test_areset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 4: number of sequenced reset domains (2..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 256: minimum cycles all affected domains stay in reset before release starts.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 1024: maximum cycles to wait for a domain acknowledge.
REQ-004 SHALL have port clock, input, 1 bit: sequencer clock, free-running, all logic on posedge.
REQ-005 SHALL have port areset, input, 1 bit: reset areset, asynchronous, active-high; clock clock.
REQ-006 SHALL have port pll_locked, input, 1 bit: asynchronous clock-generator lock, synchronized internally with 2 flops.
REQ-007 SHALL have port sw_req, input, NUM_DOMAINS bits: single-cycle request to re-reset domain k and all higher domains.
REQ-008 SHALL have port domain_ack, input, NUM_DOMAINS bits: level per domain, 1 = that domain's synchronized reset has deasserted; already synchronous to clock.
REQ-009 SHALL have port reset_out, output, NUM_DOMAINS bits: per-domain reset request, 1 = hold in reset, registered.
REQ-010 SHALL have port busy, output, 1 bit: 1 in every state except RUN.
REQ-011 SHALL have port fault, output, 1 bit: 1 in FAULT.
REQ-012 SHALL have port fault_domain, output, 3 bits: index of the domain that timed out, valid while fault=1.

Function
REQ-013 SHALL implement states HOLD, RELEASE, WAIT_ACK, RUN and FAULT, with a domain index idx (0..NUM_DOMAINS-1).
REQ-014 HOLD SHALL count consecutive cycles with synchronized lock = 1 and clear the count whenever lock = 0.
REQ-015 HOLD SHALL go to RELEASE on the cycle the count reaches HOLD_CYCLES.
REQ-016 RELEASE SHALL clear reset_out[idx] and go to WAIT_ACK next cycle, for exactly one cycle in RELEASE.
REQ-017 WAIT_ACK SHALL count cycles from 0 and, when domain_ack[idx] = 1, either increment idx and go to RELEASE, or go to RUN if idx = NUM_DOMAINS-1.
REQ-018 WAIT_ACK SHALL go to FAULT if the count reaches ACK_TIMEOUT without an ack, latching fault_domain = idx.
REQ-019 Domains SHALL be released strictly in increasing index order: reset_out[j] never clears before domain_ack[j-1] = 1.
REQ-020 RUN SHALL hold reset_out all 0 and accept sw_req.
REQ-021 On sw_req with lowest set bit k in RUN or FAULT: set reset_out[k..N-1] to 1, leave lower bits unchanged, set idx = k, clear fault and enter HOLD, all next cycle.
REQ-022 Simultaneous sw_req bits SHALL resolve to the lowest index; higher bits are discarded.
REQ-023 sw_req SHALL be ignored in HOLD, RELEASE and WAIT_ACK.
REQ-024 Synchronized lock = 0 in any state SHALL, next cycle, set reset_out to all 1, idx = 0, clear fault and enter HOLD; this takes priority over sw_req and ack.
REQ-025 FAULT SHALL hold reset_out[fault_domain..N-1] = 1 and lower bits at 0, and SHALL leave only via sw_req, lock loss or areset.
REQ-026 Loss of domain_ack[j] for j < idx during sequencing, or in RUN, SHALL be ignored.
REQ-027 Counters SHALL be sized $clog2(max(HOLD_CYCLES, ACK_TIMEOUT))+1 and SHALL saturate, never wrap.

Reset
REQ-028 areset SHALL asynchronously force: state HOLD, idx 0, reset_out all 1, busy 1, fault 0, fault_domain 0, counters 0, lock synchronizer 0.
REQ-029 Deassertion of areset SHALL take effect on the first clock edge with no further synchronization inside this block.
REQ-030 reset_out SHALL never glitch low during or immediately after areset.

Verification
REQ-031 Bench SHALL cover these cases with N=4, HOLD_CYCLES=16, ACK_TIMEOUT=32:
- Power-up: lock high at cycle 3, acks returned 2 cycles after each release -> reset_out goes 1111→1110→1100→1000→0000 in order, busy falls after the ack of domain 3.
- Lock glitch: lock low for 1 cycle during HOLD count 10 -> count restarts, release occurs 16 synchronized-high cycles after the glitch.
- Timeout: domain 2 never acks -> fault=1, fault_domain=2 and reset_out=1100 at 32 cycles into WAIT_ACK; a later sw_req=0001 restarts sequencing with reset_out=1111.
- Software reset: in RUN, sw_req=0110 -> reset_out=1110, then after HOLD domains 1,2,3 are released in order while domain 0 stays out of reset.
- Lock loss in RUN with simultaneous sw_req=1000 -> reset_out=1111 and idx=0; sw_req is discarded.
- areset asserted mid-WAIT_ACK -> reset_out=1111 immediately without waiting for a clock, fault=0.
